fp_issue_arbiter: RTL and testbench
===================================

// Module: fp_issue_arbiter
// PURPOSE
//  Shares the single FP preprocessing input port among NUM_REQ FP instruction requesters.
//  Round-robin arbitration among eligible requesters into a one-entry output register.
//  Per-unit credit counters block issue to FP units (madd/div/sqrt/wb2fp/wb2int) that lack queue space.
//  Sits between FP decode/issue sources and fp_preprocessing; drives its pkt input and observes its ready.
// PARAMETERS
//  NUM_REQ       2   number of requesters
//  FP_NUM_UNITS  5   number of FP execution units; width of the pkt.unit one-hot
//  UNIT_CREDITS  2   issue credits per unit; counter width = $clog2(UNIT_CREDITS+1)
// PORTS
//  clk              in   1                          clock
//  rst              in   1                          synchronous, active-low reset
//  req_valid        in   NUM_REQ                    requester i has a packet
//  req_pkt          in   NUM_REQ x fp_preprocessing_packet_t   packet i (.valid field ignored)
//  req_ready        out  NUM_REQ                    requester i's packet accepted this cycle (one-hot or 0)
//  out_pkt          out  fp_preprocessing_packet_t  to preprocessing; out_pkt.valid = output register valid
//  out_ready        in   1                          preprocessing ready
//  credit_return    in   FP_NUM_UNITS               unit i frees one slot (multi-hot allowed)
//  flush            in   1                          drop the buffered packet
//  unit_has_credit  out  FP_NUM_UNITS               credit_cnt[i] != 0 (for decode stall hints)
// BEHAVIOUR
//  Reset (rst==0 at posedge): out_pkt.valid=0, credit_cnt[all]=UNIT_CREDITS, rr_ptr=0;
//   req_ready=0 during reset. unit_has_credit reads all-ones the cycle after reset.
//  Eligible[i] = req_valid[i] & |(req_pkt[i].unit & unit_has_credit); pkt.unit must be one-hot (asserted).
//  Load = eligible_any & (~out_valid | out_ready) & ~flush.
//  Grant: first eligible at or after rr_ptr, wrapping. On load: req_ready[g]=1,
//   out register <- req_pkt[g], out_valid=1, rr_ptr <- (g+1) mod NUM_REQ. rr_ptr unchanged without a load.
//  Handoff: out_valid & out_ready -> out_valid=0 unless a load occurs the same cycle (back-to-back, 1 pkt/cycle).
//  Latency: request to out_pkt.valid = 1 cycle. req_ready is combinational from req_valid/credits/out_ready.
//  Credits: consumed at load (dec credit_cnt of granted unit), not at handoff.
//   Same-cycle load and credit_return to same unit: net 0. Multiple returns add independently.
//   credit_return to a unit at UNIT_CREDITS is illegal (assertion); counter saturates, no wrap.
//   Zero credits for a unit: requesters targeting it are ineligible; others proceed (no head-of-line blocking across requesters).
//  Flush: out_valid <- 0 next cycle; the dropped packet's credit is restored (+1, plus any same-cycle return);
//   no load and req_ready=0 during flush; rr_ptr held. Flush with out_valid=0 is a no-op on credits.
//   Flush has priority over handoff: out_ready is ignored in a flush cycle.
//  out_pkt fields stable while out_valid & ~out_ready (valid/ready hold rule).
//  Reset mid-operation discards the buffered packet; credits return to UNIT_CREDITS regardless of outstanding units.
// STRUCTURE
//  fpu_types: fp_preprocessing_packet_t (existing), new fp_unit_onehot_t = logic[FP_NUM_UNITS-1:0].
//  cva5_config: FP_UNIT_CREDITS default constant feeding UNIT_CREDITS.
//  Sub-module: fp_credit_counter (one per unit; inputs take/give, output has_credit) instantiated via generate.
//  Round-robin select inline (rotate-priority-encode-rotate back); no other sub-modules.
// TESTING
//  1 req0 and req1 valid every cycle, out_ready=1, distinct units -> grants alternate 0,1,0,1; one out pkt/cycle.
//  2 UNIT_CREDITS=2, three req0 pkts to unit 1, no returns -> two issue; third stalls, req_ready=0; credit_return[1] -> issues next cycle.
//  3 req0->unit0 at 0 credits, req1->unit2 has credits, rr_ptr=0 -> req1 granted; req0 waits, no deadlock.
//  4 out_valid=1, out_ready=0 for 5 cycles -> out_pkt stable, req_ready=0; out_ready=1 + pending req -> handoff and reload same cycle.
//  5 flush while buffering a unit-3 pkt at credit_cnt[3]=1 -> out_valid=0 next cycle, credit_cnt[3]=2; flush + credit_return[3] -> restored +2, saturates only at UNIT_CREDITS.
//  6 rst=0 with buffered pkt and credit_cnt[4]=0 -> next cycle out_valid=0, all credits=UNIT_CREDITS, first grant goes to req0.

Source files
------------

// File: rtl/fp_issue_arbiter_pkg.sv
// Shared types and constants for the FP issue arbiter: packet layout, unit one-hot
// encoding and the default per-unit issue credit count.
package fp_issue_arbiter_pkg;

    localparam int unsigned FP_NUM_UNITS    = 5;
    localparam int unsigned FP_UNIT_CREDITS = 2;

    typedef logic [FP_NUM_UNITS-1:0] fp_unit_onehot_t;

    typedef enum logic [2:0] {
        FpUnitMadd,
        FpUnitDiv,
        FpUnitSqrt,
        FpUnitWb2Fp,
        FpUnitWb2Int
    } fp_unit_e;

    typedef struct packed {
        logic            valid;
        fp_unit_onehot_t unit;
        logic [3:0]      op;
        logic [2:0]      rm;
        logic [7:0]      id;
        logic [31:0]     rs1;
    } fp_preprocessing_packet_t;

    function automatic fp_unit_onehot_t fp_unit_onehot(input fp_unit_e u);
        return fp_unit_onehot_t'(1) << u;
    endfunction

endpackage

// File: rtl/fp_issue_arbiter_credit.sv
// Per-unit issue credit counter: decrements on issue, increments on unit return and on
// flush of a buffered packet, saturating at the configured credit count.
module fp_credit_counter #(
    parameter int unsigned Credits = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic take_i,
    input  logic give_i,
    input  logic restore_i,
    output logic has_credit_o
);

    localparam int unsigned     CntW   = $clog2(Credits + 1);
    localparam logic [CntW+1:0] MaxCnt = (CntW + 2)'(Credits);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW+1:0] cnt_sum;

    always_comb begin
        cnt_sum = {2'b00, cnt_q} + (CntW + 2)'(give_i) + (CntW + 2)'(restore_i)
                - (CntW + 2)'(take_i);
        cnt_d   = (cnt_sum > MaxCnt) ? CntW'(Credits) : cnt_sum[CntW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= CntW'(Credits);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign has_credit_o = (cnt_q != '0);

    // A unit with every credit in hand has nothing outstanding to return.
    assert property (@(posedge clk_i) disable iff (!rst_ni) give_i |-> (cnt_q != CntW'(Credits)));
    assert property (@(posedge clk_i) disable iff (!rst_ni) take_i |-> (cnt_q != '0));

endmodule

// File: rtl/fp_issue_arbiter.sv
// Round-robin arbiter sharing the FP preprocessing port among requesters, with a one-entry
// output register and per-unit credits that keep packets away from full unit queues.
module fp_issue_arbiter
    import fp_issue_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned UnitCredits = FP_UNIT_CREDITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_valid_i,
    input  fp_preprocessing_packet_t req_pkt_i [NumReq],
    output logic [NumReq-1:0]        req_ready_o,
    output fp_preprocessing_packet_t out_pkt_o,
    input  logic                     out_ready_i,
    input  logic [FP_NUM_UNITS-1:0]  credit_return_i,
    input  logic                     flush_i,
    output logic [FP_NUM_UNITS-1:0]  unit_has_credit_o
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic                     out_valid_q, out_valid_d;
    fp_preprocessing_packet_t out_pkt_q, out_pkt_d;
    logic [PtrW-1:0]          rr_q, rr_d;

    logic [NumReq-1:0]        eligible;
    logic [2*NumReq-1:0]      elig_dbl;
    logic [NumReq-1:0]        elig_rot;
    logic [PtrW-1:0]          grant_off;
    logic [PtrW:0]            grant_sum;
    logic [PtrW-1:0]          grant_idx;
    logic [PtrW-1:0]          rr_next;
    logic                     any_eligible;
    logic                     load;
    fp_preprocessing_packet_t grant_pkt;
    fp_unit_onehot_t          take_units;
    fp_unit_onehot_t          restore_units;

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            eligible[i] = req_valid_i[i] & (|(req_pkt_i[i].unit & unit_has_credit_o));
        end
    end

    // Rotate so rr_q sits at bit 0, pick the lowest set bit, then rotate the index back.
    always_comb begin
        elig_dbl  = {eligible, eligible};
        elig_rot  = NumReq'(elig_dbl >> rr_q);
        grant_off = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                grant_off = PtrW'(i);
            end
        end
        grant_sum = (PtrW + 1)'(rr_q) + (PtrW + 1)'(grant_off);
        grant_idx = (grant_sum >= (PtrW + 1)'(NumReq)) ? PtrW'(grant_sum - (PtrW + 1)'(NumReq))
                                                        : PtrW'(grant_sum);
        rr_next   = (grant_idx == PtrW'(NumReq - 1)) ? '0 : grant_idx + PtrW'(1);
    end

    assign any_eligible = |eligible;
    assign load         = any_eligible & (~out_valid_q | out_ready_i) & ~flush_i & rst_ni;
    assign grant_pkt    = req_pkt_i[grant_idx];
    assign req_ready_o  = load ? (NumReq'(1) << grant_idx) : '0;

    assign take_units    = load ? grant_pkt.unit : '0;
    assign restore_units = (flush_i & out_valid_q) ? out_pkt_q.unit : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pkt_d   = out_pkt_q;
        rr_d        = rr_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_pkt_d   = grant_pkt;
            rr_d        = rr_next;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rr_q        <= rr_d;
        end
    end

    // Payload needs no reset; it is only observed while out_valid_q is set.
    always_ff @(posedge clk_i) begin
        out_pkt_q <= out_pkt_d;
    end

    always_comb begin
        out_pkt_o       = out_pkt_q;
        out_pkt_o.valid = out_valid_q;
    end

    for (genvar u = 0; u < FP_NUM_UNITS; u++) begin : g_credit
        fp_credit_counter #(
            .Credits(UnitCredits)
        ) u_credit_counter (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .take_i      (take_units[u]),
            .give_i      (credit_return_i[u]),
            .restore_i   (restore_units[u]),
            .has_credit_o(unit_has_credit_o[u])
        );
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_unit_onehot_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            req_valid_i[i] |-> $onehot(req_pkt_i[i].unit));
    end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Bench for fp_issue_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a credit/queue-level reference model.
module tb_fp_issue_arbiter;
    import fp_issue_arbiter_pkg::*;

    localparam int N = 2;
    localparam int C = FP_UNIT_CREDITS;
    localparam int U = FP_NUM_UNITS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [N-1:0]             req_valid;
    fp_preprocessing_packet_t req_pkt [N];
    logic [N-1:0]             req_ready;
    fp_preprocessing_packet_t out_pkt;
    logic                     out_ready;
    logic [U-1:0]             credit_return;
    logic                     flush;
    logic [U-1:0]             has_credit;

    fp_issue_arbiter #(
        .NumReq     (N),
        .UnitCredits(C)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_pkt_i        (req_pkt),
        .req_ready_o      (req_ready),
        .out_pkt_o        (out_pkt),
        .out_ready_i      (out_ready),
        .credit_return_i  (credit_return),
        .flush_i          (flush),
        .unit_has_credit_o(has_credit)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: credits as plain integers, a single buffered packet, a pointer.
    int                       m_cred [U];
    int                       handed [U];
    bit                       m_ov;
    fp_preprocessing_packet_t m_out;
    int                       m_rr;

    typedef struct {
        logic [1:0] rv;
        int         u0;
        int         u1;
        logic       ordy;
        logic [4:0] cret;
        logic [1:0] rdy;
        logic       ov;
        int         oid;
    } vec_t;

    vec_t tbl [19];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic fp_preprocessing_packet_t mk(input int unit, input int id);
        fp_preprocessing_packet_t p;
        p.valid = 1'($urandom);
        p.unit  = fp_unit_onehot_t'(1) << unit;
        p.op    = 4'($urandom);
        p.rm    = 3'($urandom);
        p.id    = 8'(id);
        p.rs1   = $urandom;
        return p;
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < U; u++) begin
            m_cred[u] = C;
            handed[u] = 0;
        end
        m_ov = 1'b0;
        m_rr = 0;
    endfunction

    function automatic int model_grant();
        if (!rst_n || flush) return -1;
        if (m_ov && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_valid[i]) begin
                for (int u = 0; u < U; u++) begin
                    if (req_pkt[i].unit[u] && m_cred[u] > 0) return i;
                end
            end
        end
        return -1;
    endfunction

    function automatic logic [U-1:0] model_mask();
        logic [U-1:0] m;
        for (int u = 0; u < U; u++) m[u] = (m_cred[u] > 0);
        return m;
    endfunction

    function automatic void model_update(input int g);
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int u = 0; u < U; u++) begin
            int d;
            d = int'(credit_return[u]);
            if (flush && m_ov && m_out.unit[u]) d++;
            if (g >= 0 && req_pkt[g].unit[u]) d--;
            m_cred[u] = (m_cred[u] + d > C) ? C : m_cred[u] + d;
            if (!flush && m_ov && out_ready && m_out.unit[u]) handed[u]++;
            handed[u] -= int'(credit_return[u]);
        end
        if (flush) begin
            m_ov = 1'b0;
        end else if (g >= 0) begin
            m_ov  = 1'b1;
            m_out = req_pkt[g];
            m_rr  = (g + 1) % N;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endfunction

    // One clock: compare at negedge against the model (plus optional fixed expectations),
    // then advance the model on the posedge. Negative expectations are skipped.
    task automatic tick(input string nm, input int e_rdy, input int e_ov, input int e_id);
        int                       g;
        logic [N-1:0]             mr;
        fp_preprocessing_packet_t ep;
        @(negedge clk);
        g  = model_grant();
        mr = (g >= 0) ? (N'(1) << g) : '0;
        chk({nm, " req_ready"}, 64'(req_ready), 64'(mr));
        chk({nm, " has_credit"}, 64'(has_credit), 64'(model_mask()));
        chk({nm, " out_valid"}, 64'(out_pkt.valid), 64'(m_ov));
        if (m_ov) begin
            ep       = m_out;
            ep.valid = 1'b1;
            chk({nm, " out_pkt"}, 64'(out_pkt), 64'(ep));
        end
        if (e_rdy >= 0) chk({nm, " req_ready fixed"}, 64'(req_ready), 64'(e_rdy));
        if (e_ov >= 0) chk({nm, " out_valid fixed"}, 64'(out_pkt.valid), 64'(e_ov));
        if (e_id >= 0) chk({nm, " out id fixed"}, 64'(out_pkt.id), 64'(e_id));
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    initial begin
        //          rv    u0 u1 ordy  cret      rdy   ov    oid
        tbl[0]  = '{2'b11, 0, 1, 1'b1, 5'b00000, 2'b01, 1'b0, -1};
        tbl[1]  = '{2'b11, 0, 1, 1'b1, 5'b00001, 2'b10, 1'b1, 0};
        tbl[2]  = '{2'b11, 0, 1, 1'b1, 5'b00010, 2'b01, 1'b1, 3};
        tbl[3]  = '{2'b11, 0, 1, 1'b1, 5'b00001, 2'b10, 1'b1, 4};
        tbl[4]  = '{2'b00, 0, 1, 1'b1, 5'b00010, 2'b00, 1'b1, 7};
        tbl[5]  = '{2'b01, 1, 1, 1'b1, 5'b00000, 2'b01, 1'b0, -1};
        tbl[6]  = '{2'b01, 1, 1, 1'b1, 5'b00000, 2'b01, 1'b1, 10};
        tbl[7]  = '{2'b01, 1, 1, 1'b1, 5'b00000, 2'b00, 1'b1, 12};
        tbl[8]  = '{2'b01, 1, 1, 1'b1, 5'b00010, 2'b00, 1'b0, -1};
        tbl[9]  = '{2'b01, 1, 1, 1'b1, 5'b00000, 2'b01, 1'b0, -1};
        tbl[10] = '{2'b00, 1, 1, 1'b1, 5'b00010, 2'b00, 1'b1, 18};
        tbl[11] = '{2'b00, 1, 1, 1'b1, 5'b00010, 2'b00, 1'b0, -1};
        tbl[12] = '{2'b01, 0, 2, 1'b1, 5'b00000, 2'b01, 1'b0, -1};
        tbl[13] = '{2'b01, 0, 2, 1'b1, 5'b00000, 2'b01, 1'b1, 24};
        tbl[14] = '{2'b10, 0, 2, 1'b1, 5'b00000, 2'b10, 1'b1, 26};
        tbl[15] = '{2'b11, 0, 2, 1'b1, 5'b00000, 2'b10, 1'b1, 29};
        tbl[16] = '{2'b11, 0, 2, 1'b1, 5'b00101, 2'b00, 1'b1, 31};
        tbl[17] = '{2'b11, 0, 2, 1'b1, 5'b00101, 2'b01, 1'b0, -1};
        tbl[18] = '{2'b00, 0, 2, 1'b1, 5'b00001, 2'b00, 1'b1, 34};

        rst_n         = 1'b0;
        req_valid     = '0;
        req_pkt[0]    = mk(0, 0);
        req_pkt[1]    = mk(1, 1);
        out_ready     = 1'b0;
        credit_return = '0;
        flush         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_pkt.valid), 64'(0));
        chk("reset has_credit", 64'(has_credit), 64'(5'h1F));
        chk("reset req_ready", 64'(req_ready), 64'(0));
        rst_n = 1'b1;

        // Alternation, credit exhaustion on one unit, and bypass of a starved requester.
        for (int k = 0; k < 19; k++) begin
            req_valid     = tbl[k].rv;
            req_pkt[0]    = mk(tbl[k].u0, k * 2);
            req_pkt[1]    = mk(tbl[k].u1, k * 2 + 1);
            out_ready     = tbl[k].ordy;
            credit_return = tbl[k].cret;
            tick($sformatf("vec%0d", k), int'(tbl[k].rdy), int'(tbl[k].ov), tbl[k].oid);
        end
        credit_return = '0;

        // Output held under backpressure, then handoff with same-cycle reload.
        req_valid  = 2'b01;
        req_pkt[0] = mk(3, 'h40);
        out_ready  = 1'b0;
        tick("s4 load", 1, 0, -1);
        req_valid  = 2'b11;
        req_pkt[0] = mk(3, 'h41);
        req_pkt[1] = mk(4, 'h42);
        for (int k = 0; k < 5; k++) tick("s4 hold", 0, 1, 'h40);
        out_ready = 1'b1;
        tick("s4 handoff", 2, 1, 'h40);
        req_valid = 2'b00;
        tick("s4 drain", 0, 1, 'h42);
        credit_return = 5'b11000;
        tick("s4 return", 0, 0, -1);
        credit_return = '0;

        // Flush restores the dropped packet's credit, alone and with a same-cycle return.
        req_valid  = 2'b01;
        req_pkt[0] = mk(3, 'h50);
        out_ready  = 1'b0;
        tick("s5 load", 1, 0, -1);
        req_valid = 2'b00;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick("s5 flush", 0, 1, 'h50);
        flush      = 1'b0;
        req_valid  = 2'b01;
        req_pkt[0] = mk(3, 'h51);
        tick("s5 reissue a", 1, 0, -1);
        req_pkt[0] = mk(3, 'h52);
        tick("s5 reissue b", 1, 1, 'h51);
        req_pkt[0]    = mk(3, 'h53);
        flush         = 1'b1;
        credit_return = 5'b01000;
        tick("s5 flush+return", 0, 1, 'h52);
        flush         = 1'b0;
        credit_return = '0;
        req_pkt[0]    = mk(3, 'h54);
        tick("s5 after a", 1, 0, -1);
        req_pkt[0] = mk(3, 'h55);
        tick("s5 after b", 1, 1, 'h54);
        req_pkt[0] = mk(3, 'h56);
        tick("s5 after stall", 0, 1, 'h55);
        req_valid     = 2'b00;
        credit_return = 5'b01000;
        tick("s5 return", 0, 0, -1);
        tick("s5 return", 0, 0, -1);
        credit_return = '0;

        // Reset with a buffered packet and an exhausted unit.
        req_valid  = 2'b01;
        req_pkt[0] = mk(4, 'h60);
        out_ready  = 1'b0;
        tick("s6 load a", 1, 0, -1);
        out_ready  = 1'b1;
        req_pkt[0] = mk(4, 'h61);
        tick("s6 load b", 1, 1, 'h60);
        req_valid  = 2'b11;
        req_pkt[0] = mk(4, 'h62);
        req_pkt[1] = mk(4, 'h63);
        out_ready  = 1'b0;
        tick("s6 blocked", 0, 1, 'h61);
        rst_n = 1'b0;
        tick("s6 in reset", 0, 1, 'h61);
        rst_n = 1'b1;
        chk("s6 credits after reset", 64'(has_credit), 64'(5'h1F));
        chk("s6 out_valid after reset", 64'(out_pkt.valid), 64'(0));
        out_ready = 1'b1;
        tick("s6 first grant", 1, 0, -1);
        req_valid = 2'b00;
        tick("s6 drain", 0, 1, 'h62);

        // Randomized traffic; returns only for packets already handed to a unit.
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(99) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_pkt[i] = mk($urandom_range(U - 1), $urandom_range(255));
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            for (int u = 0; u < U; u++) begin
                credit_return[u] = (handed[u] > 0) && ($urandom_range(2) == 0);
            end
            tick("rand", -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
